// File: rtl/lcd_st_pkg.sv
// Shared constants for the LCD Avalon-ST stream adapters.
// Payload width, FIFO depth and ready latencies on each side.
package lcd_st_pkg;

  localparam int LCD_ST_DATA_W     = 8;
  localparam int LCD_ST_FIFO_DEPTH = 4;
  localparam int LCD_ST_RL_IN      = 1;
  localparam int LCD_ST_RL_OUT     = 0;

endpackage

// File: rtl/lcd_st_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W registers, one write port, async read.
// Ports: clk, wr_en/wr_addr/wr_data write side, rd_addr -> rd_data.
module lcd_st_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_master_ready_adt.sv
// Ready-latency adapter: upstream RL=1, downstream RL=0, small FIFO.
// Ports: in_valid/in_data/in_ready, out_valid/out_data/out_ready, fill, overflow.
module lcd_master_ready_adt
  import lcd_st_pkg::*;
#(
  parameter int DATA_W = LCD_ST_DATA_W,
  parameter int DEPTH  = LCD_ST_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign rd_en     = out_valid && out_ready;
  // A full FIFO still takes a beat when the head leaves this cycle.
  assign wr_en     = in_valid && (!full || rd_en);
  assign fill      = count;

  always_comb begin
    count_next = count;
    unique case (1'b1)
      (wr_en && !rd_en): count_next = count + CW'(1);
      (rd_en && !wr_en): count_next = count - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      // Two free slots: one for the beat in flight, one spare.
      in_ready <= (count_next <= CW'(DEPTH - 2));
      if (in_valid && full && !rd_en) overflow <= 1'b1;
    end
  end

  lcd_st_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

`ifndef SYNTHESIS
  logic rdy_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_d <= 1'b0;
    else          rdy_d <= in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset_n && in_valid && !rdy_d)
      $info("lcd_master_ready_adt: in_valid after in_ready low");
  end
`endif

endmodule

// File: tb/tb_lcd_master_ready_adt.sv
// Directed bench for lcd_master_ready_adt.
// One task per scenario; expected values are hand-derived.
module tb_lcd_master_ready_adt;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] fill;
  logic       overflow;

  int n_chk;
  int n_fail;

  lcd_master_ready_adt dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .fill      (fill),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    n_chk++;
    if ({in_ready, out_valid, fill, overflow} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b ov=%b fill=%0d of=%b want 0 0 0 0",
               in_ready, out_valid, fill, overflow);
    end
    reset_n = 1'b1;
    step();
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rdy: got %b want 1", in_ready);
    end
  endtask

  task automatic test_pass_through;
    logic [7:0] d [3];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      step();
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== d[i] || fill !== 3'd1) begin
        n_fail++;
        $display("FAIL pass_beat%0d: got v=%b d=%h fill=%0d want 1 %h 1",
                 i, out_valid, out_data, fill, d[i]);
      end
    end
    in_valid = 1'b0;
    step();
    n_chk++;
    if (out_valid !== 1'b0 || fill !== 3'd0) begin
      n_fail++;
      $display("FAIL pass_empty: got v=%b fill=%0d want 0 0", out_valid, fill);
    end
  endtask

  // Four beats with out_ready low; upstream honours in_ready with RL=1.
  task automatic fill_four(input logic [7:0] base);
    logic [3:0] exp_rdy;
    exp_rdy   = 4'b0011;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      step();
      n_chk++;
      if (fill !== 3'(i + 1) || in_ready !== exp_rdy[i]) begin
        n_fail++;
        $display("FAIL fill_beat%0d: got fill=%0d rdy=%b want %0d %b",
                 i, fill, in_ready, i + 1, exp_rdy[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    fill_four(8'hA0);
    step();
    n_chk++;
    if (fill !== 3'd4 || overflow !== 1'b0 || out_valid !== 1'b1 ||
        out_data !== 8'hA0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got fill=%0d of=%b v=%b d=%h rdy=%b want 4 0 1 a0 0",
               fill, overflow, out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_chk++;
      if (fill !== 3'(4 - i) ||
          (i < 4 && out_data !== 8'(8'hA0 + i))) begin
        n_fail++;
        $display("FAIL bp_drain%0d: got fill=%0d d=%h want %0d %h",
                 i, fill, out_data, 4 - i, 8'(8'hA0 + i));
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_rw;
    logic [7:0] q [14];
    for (int i = 0; i < 4; i++) q[i] = 8'h30 + 8'(i);
    for (int i = 0; i < 10; i++) q[4 + i] = 8'h40 + 8'(i);
    fill_four(8'h30);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      step();
      n_chk++;
      if (fill !== 3'd4 || out_data !== q[i + 1] || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL full_rw%0d: got fill=%0d d=%h of=%b want 4 %h 0",
                 i, fill, out_data, overflow, q[i + 1]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_overflow;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_chk++;
    if (overflow !== 1'b1 || fill !== 3'd4 || out_data !== 8'h46) begin
      n_fail++;
      $display("FAIL ovf_set: got of=%b fill=%0d d=%h want 1 4 46",
               overflow, fill, out_data);
    end
    step();
    n_chk++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'h46 + i)) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: got v=%b d=%h want 1 %h",
                 i, out_valid, out_data, 8'(8'h46 + i));
      end
      step();
    end
    n_chk++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_after: got v=%b of=%b want 0 1", out_valid, overflow);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap;
    logic [7:0] pat;
    logic       prev_rdy;
    int         sent;
    int         rcvd;
    int         cyc;
    pat      = 8'b1011_0010;
    prev_rdy = 1'b0;
    sent     = 0;
    rcvd     = 0;
    cyc      = 0;
    while ((sent < 8 || rcvd < 8) && cyc < 100) begin
      out_ready = pat[cyc % 8];
      if (out_valid && out_ready) begin
        n_chk++;
        if (out_data !== 8'(8'h50 + rcvd)) begin
          n_fail++;
          $display("FAIL wrap_beat%0d: got %h want %h",
                   rcvd, out_data, 8'(8'h50 + rcvd));
        end
        rcvd++;
      end
      in_valid = (sent < 8) && prev_rdy;
      in_data  = 8'(8'h50 + sent);
      if (in_valid) sent++;
      prev_rdy = in_ready;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_chk++;
    if (rcvd != 8 || fill !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_done: got rcvd=%0d fill=%0d want 8 0", rcvd, fill);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h60 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    n_chk++;
    if (fill !== 3'd3) begin
      n_fail++;
      $display("FAIL rstmid_pre: got fill=%0d want 3", fill);
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({in_ready, out_valid, fill, overflow} !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got rdy=%b v=%b fill=%0d of=%b want 0 0 0 0",
               in_ready, out_valid, fill, overflow);
    end
    step();
    reset_n = 1'b1;
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_hold: got rdy=%b want 0", in_ready);
    end
    step();
    n_chk++;
    if (in_ready !== 1'b1 || fill !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_release: got rdy=%b fill=%0d v=%b want 1 0 0",
               in_ready, fill, out_valid);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_pass_through();
    test_backpressure();
    test_full_rw();
    test_overflow();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
